andla_ldma_pad_wr: RTL

ANDLA_LDMA_PAD_WR -- requirements
Module: andla_ldma_pad_wr

---
 rtl/andla_ldma_pad_wr_pkg.sv | 17 +
 rtl/andla_ldma_pad_cnt.sv | 109 ++++++++++
 rtl/andla_ldma_pad_wr.sv | 134 +++++++++++++
 3 files changed

// File: rtl/andla_ldma_pad_wr_pkg.sv
// Shared definitions for the LDMA padded SHRAM write path: default
// bitwidths and the controller state encoding.
package andla_ldma_pad_wr_pkg;

    localparam int LDMA_DATA_W = 64;
    localparam int LDMA_ADDR_W = 20;
    localparam int LDMA_DIM_W  = 16;
    localparam int LDMA_PAD_W  = 4;
    localparam int LDMA_STR_W  = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pad_wr_state_e;

endpackage

// File: rtl/andla_ldma_pad_cnt.sv
// Nested w/h/n walker over the padded grid. Addresses are built by adding
// strides into column, row and plane accumulators, so no multiplier is
// needed. Reports whether the current point is interior and whether it is
// the final point of the transfer.
module andla_ldma_pad_cnt
    import andla_ldma_pad_wr_pkg::*;
#(
    parameter int ADDR_W = LDMA_ADDR_W,
    parameter int DIM_W  = LDMA_DIM_W,
    parameter int PAD_W  = LDMA_PAD_W,
    parameter int STR_W  = LDMA_STR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              adv,
    input  logic [ADDR_W-1:0] base,
    input  logic [DIM_W-1:0]  dim_w,
    input  logic [DIM_W-1:0]  dim_h,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic [PAD_W-1:0]  pad_left,
    input  logic [PAD_W-1:0]  pad_right,
    input  logic [PAD_W-1:0]  pad_up,
    input  logic [PAD_W-1:0]  pad_down,
    input  logic [STR_W-1:0]  stride_w,
    input  logic [STR_W-1:0]  stride_h,
    input  logic [STR_W-1:0]  stride_n,
    output logic [ADDR_W-1:0] addr,
    output logic              interior,
    output logic              last
);

    // One extra bit so pad_left + W + pad_right cannot overflow.
    localparam int CW = DIM_W + 1;

    logic [CW-1:0]     w_cnt, h_cnt, n_cnt;
    logic [CW-1:0]     pw_m1, ph_m1, n_m1;
    logic [CW-1:0]     x_lo, x_hi, y_lo, y_hi;
    logic [ADDR_W-1:0] st_w, st_h, st_n;
    logic [ADDR_W-1:0] addr_q, row_q, plane_q;
    logic [ADDR_W-1:0] next_row, next_plane;
    logic              w_wrap, h_wrap;

    assign w_wrap     = (w_cnt == pw_m1);
    assign h_wrap     = (h_cnt == ph_m1);
    assign next_row   = row_q + st_h;
    assign next_plane = plane_q + st_n;
    assign addr       = addr_q;
    assign last       = w_wrap && h_wrap && (n_cnt == n_m1);
    assign interior   = (w_cnt >= x_lo) && (w_cnt < x_hi) &&
                        (h_cnt >= y_lo) && (h_cnt < y_hi);

    // Capture the geometry at launch, then step w fastest, then h, then n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_cnt   <= '0;
            h_cnt   <= '0;
            n_cnt   <= '0;
            pw_m1   <= '0;
            ph_m1   <= '0;
            n_m1    <= '0;
            x_lo    <= '0;
            x_hi    <= '0;
            y_lo    <= '0;
            y_hi    <= '0;
            st_w    <= '0;
            st_h    <= '0;
            st_n    <= '0;
            addr_q  <= '0;
            row_q   <= '0;
            plane_q <= '0;
        end else if (load) begin
            w_cnt   <= '0;
            h_cnt   <= '0;
            n_cnt   <= '0;
            pw_m1   <= CW'(pad_left) + CW'(dim_w) + CW'(pad_right) - CW'(1);
            ph_m1   <= CW'(pad_up) + CW'(dim_h) + CW'(pad_down) - CW'(1);
            n_m1    <= CW'(dim_n) - CW'(1);
            x_lo    <= CW'(pad_left);
            x_hi    <= CW'(pad_left) + CW'(dim_w);
            y_lo    <= CW'(pad_up);
            y_hi    <= CW'(pad_up) + CW'(dim_h);
            st_w    <= ADDR_W'(stride_w);
            st_h    <= ADDR_W'(stride_h);
            st_n    <= ADDR_W'(stride_n);
            addr_q  <= base;
            row_q   <= base;
            plane_q <= base;
        end else if (adv) begin
            if (!w_wrap) begin
                w_cnt  <= w_cnt + CW'(1);
                addr_q <= addr_q + st_w;
            end else if (!h_wrap) begin
                w_cnt  <= '0;
                h_cnt  <= h_cnt + CW'(1);
                row_q  <= next_row;
                addr_q <= next_row;
            end else begin
                w_cnt   <= '0;
                h_cnt   <= '0;
                n_cnt   <= n_cnt + CW'(1);
                plane_q <= next_plane;
                row_q   <= next_plane;
                addr_q  <= next_plane;
            end
        end
    end

endmodule

// File: rtl/andla_ldma_pad_wr.sv
// LDMA padded SHRAM writer: expands an unpadded raster element stream into a
// padded grid, filling border points with a constant, and issues one SHRAM
// write per grid point through a single output register.
//
// Handshakes: a beat transfers on a rising edge where valid && ready. A
// producer holds valid and its payload stable until that edge; in_ready and
// wr_valid follow the same rule. in_data is only consumed on interior points.
module andla_ldma_pad_wr
    import andla_ldma_pad_wr_pkg::*;
#(
    parameter int DATA_W = LDMA_DATA_W,
    parameter int ADDR_W = LDMA_ADDR_W,
    parameter int DIM_W  = LDMA_DIM_W,
    parameter int PAD_W  = LDMA_PAD_W,
    parameter int STR_W  = LDMA_STR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] rf_ldma_shram_addr,
    input  logic [DIM_W-1:0]  rf_ldma_shram_w,
    input  logic [DIM_W-1:0]  rf_ldma_shram_h,
    input  logic [DIM_W-1:0]  rf_ldma_shram_n,
    input  logic [PAD_W-1:0]  rf_ldma_shram_pad_left,
    input  logic [PAD_W-1:0]  rf_ldma_shram_pad_right,
    input  logic [PAD_W-1:0]  rf_ldma_shram_pad_up,
    input  logic [PAD_W-1:0]  rf_ldma_shram_pad_down,
    input  logic [DATA_W-1:0] rf_ldma_ram_padding_value,
    input  logic [STR_W-1:0]  rf_ldma_shram_stride_w_size,
    input  logic [STR_W-1:0]  rf_ldma_shram_stride_h_size,
    input  logic [STR_W-1:0]  rf_ldma_shram_stride_n_size,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    pad_wr_state_e     state, state_nxt;
    logic              cnt_load, can_load, out_free, cfg_empty;
    logic              fin;
    logic [DATA_W-1:0] pad_val;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_interior, cnt_last;

    assign out_free  = !wr_valid || wr_ready;
    assign cfg_empty = (rf_ldma_shram_w == '0) || (rf_ldma_shram_h == '0) ||
                       (rf_ldma_shram_n == '0);
    assign can_load  = (state == ST_RUN) && !fin && out_free &&
                       (!cnt_interior || in_valid);
    assign in_ready  = (state == ST_RUN) && !fin && cnt_interior && out_free;
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

    andla_ldma_pad_cnt #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W),
        .PAD_W  (PAD_W),
        .STR_W  (STR_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cnt_load),
        .adv       (can_load),
        .base      (rf_ldma_shram_addr),
        .dim_w     (rf_ldma_shram_w),
        .dim_h     (rf_ldma_shram_h),
        .dim_n     (rf_ldma_shram_n),
        .pad_left  (rf_ldma_shram_pad_left),
        .pad_right (rf_ldma_shram_pad_right),
        .pad_up    (rf_ldma_shram_pad_up),
        .pad_down  (rf_ldma_shram_pad_down),
        .stride_w  (rf_ldma_shram_stride_w_size),
        .stride_h  (rf_ldma_shram_stride_h_size),
        .stride_n  (rf_ldma_shram_stride_n_size),
        .addr      (cnt_addr),
        .interior  (cnt_interior),
        .last      (cnt_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: leave RUN only once the final element has drained out of
    // the output register, so done never overlaps a pending write.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        unique case (state)
            ST_IDLE: if (start) begin
                state_nxt = ST_RUN;
                cnt_load  = 1'b1;
            end
            ST_RUN:  if (fin && out_free) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Completion flag, fill value capture and the single output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin      <= 1'b0;
            pad_val  <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            if (cnt_load) begin
                fin     <= cfg_empty;
                pad_val <= rf_ldma_ram_padding_value;
            end else if (can_load && cnt_last) begin
                fin <= 1'b1;
            end
            if (can_load) begin
                wr_valid <= 1'b1;
                wr_addr  <= cnt_addr;
                wr_data  <= cnt_interior ? in_data : pad_val;
            end else if (wr_ready) begin
                wr_valid <= 1'b0;
            end
        end
    end

endmodule
